c2c_arbiter: RTL and testbench
==============================

Name: c2c_arbiter

Overview:
- Shares one downstream c2c_data master port (unified memory / L1) between two upstream requesters: instruction fetch (port a) and the load-store unit (port b).
- Sequences each transaction: arbitrate, grant, forward, pass ack back, release.
- Round-robin or fixed-priority grant, selected by parameter.
- Atomic (AMO / LR / SC) transactions are forwarded intact, and the grant is held for their duration.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate priority after each completed grant; 0 = fixed priority, port b (LSU) always wins ties.
- XLEN, 64, data width; must match the pipeline package XLEN.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- req_a  c2c_data.slave  intf  fetch-side requester (addr, data_w, sel[7:0], re, we, amo_op[4:0], atomic in; data_r[XLEN-1:0], ack out)
- req_b  c2c_data.slave  intf  LSU-side requester, same signal set
- mem  c2c_data.master  intf  shared downstream port
- owner  output  2  debug: 2'b00 none, 2'b01 a, 2'b10 b
- arb_busy  output  1  high while a grant is active

Behaviour:
- Bus protocol: a requester holds re or we (never both) plus stable addr, data_w, sel, amo_op and atomic until it sees ack. ack is a single-cycle pulse; the requester drops re/we in the same cycle ack is high.
- State machine, registered: IDLE, GNT_A, GNT_B.
- IDLE:
  - No request forwarded; mem.re = mem.we = 0.
  - If exactly one requester has re|we, move to that requester's GNT state on the next edge.
  - If both request: fixed mode -> GNT_B. Round-robin mode -> the port that did not win last; the last_win register resets to a, so b wins the first tie.
- GNT_x:
  - All mem request fields driven combinationally from port x.
  - data_r and ack are routed to port x only. The other port sees ack = 0; its data_r is driven with mem.data_r but must be ignored.
- Leaving GNT_x:
  - When mem.ack = 1, return to IDLE next cycle and update last_win = x.
  - If port x drops re and we without ack (requester flush), abort: mem.re/we fall in the same cycle (combinational passthrough), return to IDLE, last_win unchanged.
- Latency:
  - Exactly one cycle of arbitration overhead. A request first seen in cycle n appears on mem in cycle n+1.
  - Back-to-back transactions from the same or the other port are separated by one IDLE cycle.
- Atomic transactions need no extra lock: the whole AMO is a single re/we transaction, and the grant is already held until ack.
- A new request arriving on the non-owner port during GNT_x waits; it is never dropped.
- mem.ack while in IDLE (spurious) is ignored and not forwarded.
- owner mirrors state; arb_busy = (state != IDLE).
- Reset values: state IDLE, last_win = a, owner 2'b00, arb_busy 0, mem.re 0, mem.we 0, req_a.ack 0, req_b.ack 0.
- Reset mid-transaction: all of the above take effect immediately (asynchronous). An in-flight downstream access is abandoned, and the memory side must tolerate re/we falling.

Decomposition:
- Shared package (pipeline or a new bus_pkg): arbiter state enum, owner encoding constants, the c2c sel width constant (8).
- Sub-module: rr_pick, a combinational 2-way round-robin picker with inputs req[1:0], last_win and rr_en, output win. It is reusable when a third requester (PTW) is added.

Test Plan:
- Only b issues re to addr 0x1000 with sel 0x0F -> mem.re rises next cycle. mem.ack after 3 cycles returns data_r 0xDEADBEEF to req_b.ack/data_r only; owner 2'b10 during the grant, then 2'b00.
- a and b both request from reset, ROUND_ROBIN = 1 -> grant order b, a, b, a over 4 transactions, each separated by exactly one IDLE cycle. With ROUND_ROBIN = 0 -> b repeatedly, and a is served only when b goes idle.
- a granted with mem.ack delayed 10 cycles while b requests at cycle 2 -> b's ack stays 0 and b is untouched until a completes; b's grant then starts one cycle after a's ack.
- b issues atomic = 1, amo_op = 5'b00001, we = 1 -> amo_op, atomic and data_w reach mem unchanged, and a is blocked until ack.
- a granted, then drops re after 2 cycles with no ack -> mem.re falls the same cycle, state is IDLE next cycle, last_win unchanged, a later spurious mem.ack is not forwarded.
- rst_n pulled low mid-grant -> mem.re/we, both acks and arb_busy go 0 without a clock edge. After release, a tie is won by b.

Source files
------------

// File: rtl/c2c_arbiter_pkg.sv
// rtl/c2c_arbiter_pkg.sv - shared types and constants for the c2c port arbiter
package c2c_arbiter_pkg;

    localparam int C2C_SEL_W = 8;
    localparam int AMO_OP_W  = 5;

    // State encoding doubles as the debug owner code.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_A = 2'b01,
        ARB_GNT_B = 2'b10
    } arb_state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    localparam logic WIN_A = 1'b0;
    localparam logic WIN_B = 1'b1;

endpackage

// File: rtl/c2c_arbiter_if.sv
// rtl/c2c_arbiter_if.sv - c2c_data request/response bus with master and slave views
interface c2c_data
    import c2c_arbiter_pkg::*;
#(
    parameter int XLEN = 64
);

    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      data_w;
    logic [XLEN-1:0]      data_r;
    logic [C2C_SEL_W-1:0] sel;
    logic                 re;
    logic                 we;
    logic [AMO_OP_W-1:0]  amo_op;
    logic                 atomic;
    logic                 ack;

    modport master (
        output addr, data_w, sel, re, we, amo_op, atomic,
        input  data_r, ack
    );

    modport slave (
        input  addr, data_w, sel, re, we, amo_op, atomic,
        output data_r, ack
    );

endinterface

// File: rtl/c2c_arbiter_rr_pick.sv
// rtl/c2c_arbiter_rr_pick.sv - combinational 2-way picker, round-robin or b-wins-ties
module rr_pick
    import c2c_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_win,
    input  logic       rr_en,
    output logic       win
);

    // win is only meaningful while some req bit is set.
    always_comb begin
        win = WIN_A;
        unique case (req)
            2'b01:   win = WIN_A;
            2'b10:   win = WIN_B;
            2'b11:   win = rr_en ? ~last_win : WIN_B;
            default: win = WIN_A;
        endcase
    end

endmodule

// File: rtl/c2c_arbiter.sv
// rtl/c2c_arbiter.sv - shares one c2c_data master port between fetch (a) and LSU (b)
module c2c_arbiter
    import c2c_arbiter_pkg::*;
#(
    parameter int ROUND_ROBIN = 1,
    parameter int XLEN        = 64
)(
    input  logic        clk,
    input  logic        rst_n,
    c2c_data.slave      req_a,
    c2c_data.slave      req_b,
    c2c_data.master     mem,
    output logic [1:0]  owner,
    output logic        arb_busy
);

    localparam logic [XLEN-1:0] ZERO_W = '0;

    arb_state_e state_q, state_d;
    logic       last_win_q, last_win_d;
    logic       a_req, b_req;
    logic       grant_a, grant_b;
    logic       pick_win;

    assign a_req   = req_a.re | req_a.we;
    assign b_req   = req_b.re | req_b.we;
    assign grant_a = (state_q == ARB_GNT_A);
    assign grant_b = (state_q == ARB_GNT_B);

    rr_pick u_rr_pick (
        .req      ({b_req, a_req}),
        .last_win (last_win_q),
        .rr_en    (ROUND_ROBIN != 0),
        .win      (pick_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            last_win_q <= WIN_A;
        end else begin
            state_q    <= state_d;
            last_win_q <= last_win_d;
        end
    end

    // A requester dropping re/we without ack is a flush: release without
    // touching last_win so the aborted port keeps its fairness standing.
    always_comb begin
        state_d    = state_q;
        last_win_d = last_win_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (a_req || b_req)
                    state_d = (pick_win == WIN_B) ? ARB_GNT_B : ARB_GNT_A;
            end
            ARB_GNT_A: begin
                if (mem.ack) begin
                    state_d    = ARB_IDLE;
                    last_win_d = WIN_A;
                end else if (!a_req) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GNT_B: begin
                if (mem.ack) begin
                    state_d    = ARB_IDLE;
                    last_win_d = WIN_B;
                end else if (!b_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Request fields pass straight through from the owner, so an abort or an
    // asynchronous reset drops mem.re/we without waiting for a clock edge.
    always_comb begin
        mem.addr   = ZERO_W;
        mem.data_w = ZERO_W;
        mem.sel    = '0;
        mem.re     = 1'b0;
        mem.we     = 1'b0;
        mem.amo_op = '0;
        mem.atomic = 1'b0;
        if (grant_a) begin
            mem.addr   = req_a.addr;
            mem.data_w = req_a.data_w;
            mem.sel    = req_a.sel;
            mem.re     = req_a.re;
            mem.we     = req_a.we;
            mem.amo_op = req_a.amo_op;
            mem.atomic = req_a.atomic;
        end else if (grant_b) begin
            mem.addr   = req_b.addr;
            mem.data_w = req_b.data_w;
            mem.sel    = req_b.sel;
            mem.re     = req_b.re;
            mem.we     = req_b.we;
            mem.amo_op = req_b.amo_op;
            mem.atomic = req_b.atomic;
        end
    end

    assign req_a.data_r = mem.data_r;
    assign req_b.data_r = mem.data_r;
    assign req_a.ack    = grant_a & mem.ack;
    assign req_b.ack    = grant_b & mem.ack;

    assign owner    = state_q;
    assign arb_busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_c2c_arbiter.sv
// tb/tb_c2c_arbiter.sv - directed self-checking bench for c2c_arbiter (RR and fixed instances)
module tb_c2c_arbiter;

    logic clk;
    logic rst_n;

    logic        a_re, a_we, b_re, b_we, a_atom, b_atom;
    logic [63:0] a_addr, b_addr, a_wdata, b_wdata, mem_rdata;
    logic [7:0]  a_sel, b_sel;
    logic [4:0]  a_amo, b_amo;
    logic        rr_ack, fp_ack;

    logic [1:0]  r_owner, f_owner;
    logic        r_busy, f_busy;

    int checks   = 0;
    int failures = 0;

    c2c_data #(.XLEN(64)) ra ();
    c2c_data #(.XLEN(64)) rb ();
    c2c_data #(.XLEN(64)) rm ();
    c2c_data #(.XLEN(64)) fa ();
    c2c_data #(.XLEN(64)) fb ();
    c2c_data #(.XLEN(64)) fm ();

    assign ra.re = a_re;   assign ra.we = a_we;     assign ra.addr = a_addr; assign ra.sel = a_sel;
    assign ra.data_w = a_wdata; assign ra.amo_op = a_amo; assign ra.atomic = a_atom;
    assign fa.re = a_re;   assign fa.we = a_we;     assign fa.addr = a_addr; assign fa.sel = a_sel;
    assign fa.data_w = a_wdata; assign fa.amo_op = a_amo; assign fa.atomic = a_atom;
    assign rb.re = b_re;   assign rb.we = b_we;     assign rb.addr = b_addr; assign rb.sel = b_sel;
    assign rb.data_w = b_wdata; assign rb.amo_op = b_amo; assign rb.atomic = b_atom;
    assign fb.re = b_re;   assign fb.we = b_we;     assign fb.addr = b_addr; assign fb.sel = b_sel;
    assign fb.data_w = b_wdata; assign fb.amo_op = b_amo; assign fb.atomic = b_atom;
    assign rm.ack = rr_ack; assign rm.data_r = mem_rdata;
    assign fm.ack = fp_ack; assign fm.data_r = mem_rdata;

    c2c_arbiter #(.ROUND_ROBIN(1), .XLEN(64)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_a(ra), .req_b(rb), .mem(rm),
        .owner(r_owner), .arb_busy(r_busy)
    );

    c2c_arbiter #(.ROUND_ROBIN(0), .XLEN(64)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_a(fa), .req_b(fb), .mem(fm),
        .owner(f_owner), .arb_busy(f_busy)
    );

    logic sel_fp;
    wire [1:0] cur_owner = sel_fp ? f_owner : r_owner;
    wire       cur_a_ack = sel_fp ? fa.ack : ra.ack;
    wire       cur_b_ack = sel_fp ? fb.ack : rb.ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_ack(input logic v);
        if (sel_fp) fp_ack = v;
        else        rr_ack = v;
    endtask

    // One complete grant with a single-cycle ack; winner drops its request on ack.
    task automatic serve(input string tag, input logic [1:0] exp_own);
        #1 check({tag, "_idle"}, cur_owner, 2'b00);
        tick();
        #1 check({tag, "_owner"}, cur_owner, exp_own);
        set_ack(1'b1);
        #1 check({tag, "_ack_a"}, cur_a_ack, exp_own == 2'b01);
        check({tag, "_ack_b"}, cur_b_ack, exp_own == 2'b10);
        if (exp_own == 2'b10) b_re = 1'b0;
        else                  a_re = 1'b0;
        tick();
        set_ack(1'b0);
    endtask

    initial begin
        rst_n = 1'b0; sel_fp = 1'b0;
        a_re = 0; a_we = 0; b_re = 0; b_we = 0; a_atom = 0; b_atom = 0;
        a_addr = 64'h2000; b_addr = 64'h1000; a_wdata = 0; b_wdata = 0;
        a_sel = 8'hFF; b_sel = 8'h0F; a_amo = 0; b_amo = 0;
        rr_ack = 0; fp_ack = 0; mem_rdata = 0;

        @(negedge clk);
        #1 check("rst_owner", r_owner, 2'b00);
        check("rst_busy", r_busy, 1'b0);
        check("rst_mem_re", rm.re, 1'b0);
        check("rst_mem_we", rm.we, 1'b0);
        check("rst_ack_a", ra.ack, 1'b0);
        check("rst_ack_b", rb.ack, 1'b0);
        tick();
        rst_n = 1'b1;

        // b alone, read with 3-cycle memory latency
        b_re = 1'b1;
        #1 check("t1_idle_re", rm.re, 1'b0);
        tick();
        #1 check("t1_mem_re", rm.re, 1'b1);
        check("t1_addr", rm.addr, 64'h1000);
        check("t1_sel", rm.sel, 8'h0F);
        check("t1_owner", r_owner, 2'b10);
        tick();
        tick();
        rr_ack = 1'b1; mem_rdata = 64'hDEADBEEF;
        #1 check("t1_ack_b", rb.ack, 1'b1);
        check("t1_rdata_b", rb.data_r, 64'hDEADBEEF);
        check("t1_ack_a", ra.ack, 1'b0);
        b_re = 1'b0;
        tick();
        rr_ack = 1'b0;
        #1 check("t1_owner_end", r_owner, 2'b00);
        check("t1_busy_end", r_busy, 1'b0);

        // continuous tie, round-robin: b, a, b, a
        do_reset();
        sel_fp = 1'b0;
        a_re = 1'b1; b_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve("t2_rr", (i % 2 == 0) ? 2'b10 : 2'b01);
            a_re = 1'b1; b_re = 1'b1;
        end

        // continuous tie, fixed priority: b until it goes idle, then a
        do_reset();
        sel_fp = 1'b1;
        a_re = 1'b1; b_re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve("t2_fp_b", 2'b10);
            if (i < 2) b_re = 1'b1;
        end
        serve("t2_fp_a", 2'b01);
        sel_fp = 1'b0;
        a_re = 1'b0; b_re = 1'b0;

        // a holds the grant through a 10-cycle ack; b waits
        do_reset();
        a_re = 1'b1;
        tick();
        #1 check("t3_owner_a", r_owner, 2'b01);
        tick();
        b_re = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1 check("t3_wait_ack_b", rb.ack, 1'b0);
            check("t3_wait_owner", r_owner, 2'b01);
            tick();
        end
        rr_ack = 1'b1;
        #1 check("t3_ack_a", ra.ack, 1'b1);
        check("t3_ack_b", rb.ack, 1'b0);
        a_re = 1'b0;
        tick();
        rr_ack = 1'b0;
        #1 check("t3_gap_owner", r_owner, 2'b00);
        check("t3_gap_re", rm.re, 1'b0);
        tick();
        #1 check("t3_owner_b", r_owner, 2'b10);
        check("t3_addr_b", rm.addr, 64'h1000);
        rr_ack = 1'b1; b_re = 1'b0;
        tick();
        rr_ack = 1'b0;

        // atomic write from b passes through intact, a blocked
        b_we = 1'b1; b_atom = 1'b1; b_amo = 5'b00001; b_wdata = 64'h0123_4567_89AB_CDEF;
        tick();
        a_re = 1'b1;
        #1 check("t4_owner", r_owner, 2'b10);
        check("t4_we", rm.we, 1'b1);
        check("t4_re", rm.re, 1'b0);
        check("t4_atomic", rm.atomic, 1'b1);
        check("t4_amo", rm.amo_op, 5'b00001);
        check("t4_wdata", rm.data_w, 64'h0123_4567_89AB_CDEF);
        tick();
        #1 check("t4_blocked_a", ra.ack, 1'b0);
        check("t4_owner_hold", r_owner, 2'b10);
        rr_ack = 1'b1;
        #1 check("t4_ack_b", rb.ack, 1'b1);
        check("t4_ack_a", ra.ack, 1'b0);
        b_we = 1'b0; b_atom = 1'b0; b_amo = 5'b0;
        tick();
        rr_ack = 1'b0;
        #1 check("t4_gap", r_owner, 2'b00);
        tick();
        #1 check("t4_then_a", r_owner, 2'b01);
        rr_ack = 1'b1; a_re = 1'b0;
        tick();
        rr_ack = 1'b0;

        // b completes so last_win = b; then a aborts without ack
        b_re = 1'b1;
        tick();
        rr_ack = 1'b1; b_re = 1'b0;
        tick();
        rr_ack = 1'b0;
        a_re = 1'b1;
        tick();
        #1 check("t5_owner_a", r_owner, 2'b01);
        check("t5_mem_re", rm.re, 1'b1);
        tick();
        tick();
        a_re = 1'b0;
        #1 check("t5_abort_re", rm.re, 1'b0);
        check("t5_abort_busy", r_busy, 1'b1);
        tick();
        #1 check("t5_idle", r_busy, 1'b0);
        rr_ack = 1'b1;
        #1 check("t5_spur_a", ra.ack, 1'b0);
        check("t5_spur_b", rb.ack, 1'b0);
        rr_ack = 1'b0;
        a_re = 1'b1; b_re = 1'b1;
        tick();
        #1 check("t5_tie_after_abort", r_owner, 2'b01);
        rr_ack = 1'b1; a_re = 1'b0; b_re = 1'b0;
        tick();
        rr_ack = 1'b0;

        // asynchronous reset mid-grant
        a_re = 1'b1; b_re = 1'b1;
        tick();
        #1 check("t6_busy", r_busy, 1'b1);
        rr_ack = 1'b1;
        rst_n = 1'b0;
        #1 check("t6_re", rm.re, 1'b0);
        check("t6_we", rm.we, 1'b0);
        check("t6_ack_a", ra.ack, 1'b0);
        check("t6_ack_b", rb.ack, 1'b0);
        check("t6_busy0", r_busy, 1'b0);
        check("t6_owner0", r_owner, 2'b00);
        rr_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        #1 check("t6_idle_after", r_owner, 2'b00);
        tick();
        #1 check("t6_tie_b", r_owner, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
